// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the MULT/MULTU shift-add sequencer: state encoding and
// guard-counter sizing helper.
package mult_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   // Guard terminal value: nominal WIDTH iterations plus two cycles of slack for a late K.
   function automatic int unsigned guard_limit(input int unsigned width);
      return width + 32'd2;
   endfunction

endpackage

// File: rtl/mult_ctrl_guard.sv
// Iteration guard counter: cleared before the iteration phase, counts RUN cycles and
// flags the cycle in which the count reaches LIMIT.
module mult_ctrl_guard #(
   parameter int unsigned GUARD_W = 6,
   parameter int unsigned LIMIT   = 34
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic term_c_o
);

   if (LIMIT > (2 ** GUARD_W) - 1) begin : g_guard_w_chk
      $error("mult_ctrl_guard: GUARD_W too narrow to hold LIMIT");
   end

   logic [GUARD_W-1:0] cnt_q;
   logic [GUARD_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + GUARD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High in the enabled cycle whose increment would make the count reach LIMIT.
   assign term_c_o = en_i && (cnt_q == GUARD_W'(LIMIT - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencing FSM for the MIPS shift-add multiplier: load, iterate until the external
// Counter raises K, optionally negate for signed results, then report Done or Error.
module mult_control
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned GUARD_W = 6
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Start,
   input  logic Signed,
   input  logic A_sign,
   input  logic B_sign,
   input  logic Q0,
   input  logic K,
   output logic Load,
   output logic Add,
   output logic Shift,
   output logic Negate,
   output logic Busy,
   output logic Done,
   output logic Error
);

   localparam int unsigned LIMIT = guard_limit(WIDTH);

   state_e state_q, state_d;
   logic   neg_q, neg_d;
   logic   guard_clr, guard_en, guard_term;
   logic   load_q, load_d;
   logic   shift_q, shift_d;
   logic   negate_q, negate_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   error_q, error_d;

   mult_ctrl_guard #(
      .GUARD_W (GUARD_W),
      .LIMIT   (LIMIT)
   ) u_guard (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .clr_i    (guard_clr),
      .en_i     (guard_en),
      .term_c_o (guard_term)
   );

   // Next-state decode; outputs are decoded from the next state so they register with it.
   always_comb begin
      state_d   = state_q;
      neg_d     = neg_q;
      guard_clr = 1'b0;
      guard_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               neg_d   = Signed & (A_sign ^ B_sign);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            guard_clr = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            guard_en = 1'b1;
            if (K) begin
               state_d = neg_q ? ST_FIX : ST_DONE;
            end else if (guard_term) begin
               state_d = ST_ERR;
            end
         end
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      load_d   = (state_d == ST_LOAD);
      shift_d  = (state_d == ST_RUN);
      negate_d = (state_d == ST_FIX);
      busy_d   = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_FIX);
      done_d   = (state_d == ST_DONE);
      error_d  = (state_d == ST_ERR);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         neg_q    <= 1'b0;
         load_q   <= 1'b0;
         shift_q  <= 1'b0;
         negate_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         neg_q    <= neg_d;
         load_q   <= load_d;
         shift_q  <= shift_d;
         negate_q <= negate_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign Load   = load_q;
   assign Shift  = shift_q;
   assign Negate = negate_q;
   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Error  = error_q;
   // Accumulate follows the live multiplier LSB, only during iteration cycles.
   assign Add    = shift_q & Q0;

endmodule
